// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage direct-mapped branch predictor (2-bit saturating
//               counters plus stored targets) with EX-stage resolution check,
//               mispredict redirect and saturating branch/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      if_pc_i,
    output logic             pred_taken_o,
    output logic [31:0]      pred_target_o,
    input  logic             ex_valid_i,
    input  logic [31:0]      ex_pc_i,
    input  logic             ex_taken_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [31:0]      ex_pred_target_i,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] miss_count_o
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    // Table storage: one valid bit, tag, target and counter per entry
    logic              valid_q  [ENTRIES];
    logic [TAGW-1:0]   tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [CNT_W-1:0]  br_count_q;
    logic [CNT_W-1:0]  miss_count_q;

    logic [IDXW-1:0]   w_if_idx;
    logic [TAGW-1:0]   w_if_tag;
    logic              w_if_hit;
    logic [IDXW-1:0]   w_ex_idx;
    logic [TAGW-1:0]   w_ex_tag;
    logic              w_ex_hit;
    logic [1:0]        ctr_d;

    // Fetch-side lookup reads the registered table only, so a same-cycle
    // update is not visible until the following cycle.
    assign w_if_idx      = if_pc_i[IDXW+1:2];
    assign w_if_tag      = if_pc_i[31:IDXW+2];
    assign w_if_hit      = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
    assign pred_taken_o  = w_if_hit && ctr_q[w_if_idx][1];
    assign pred_target_o = pred_taken_o ? target_q[w_if_idx] : (if_pc_i + 32'd4);

    // Resolution check: wrong direction, or right direction with wrong target
    assign mispredict_o  = ex_valid_i &&
                           ((ex_taken_i != ex_pred_taken_i) ||
                            (ex_taken_i && (ex_pred_target_i != ex_target_i)));
    assign redirect_pc_o = ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4);

    assign w_ex_idx = ex_pc_i[IDXW+1:2];
    assign w_ex_tag = ex_pc_i[31:IDXW+2];
    assign w_ex_hit = valid_q[w_ex_idx] && (tag_q[w_ex_idx] == w_ex_tag);

    // Next counter value for the resolving entry, clamped at 00 and 11
    always_comb begin
        ctr_d = ctr_q[w_ex_idx];
        if (ex_taken_i) begin
            if (ctr_q[w_ex_idx] != 2'b11) begin
                ctr_d = ctr_q[w_ex_idx] + 2'b01;
            end
        end else begin
            if (ctr_q[w_ex_idx] != 2'b00) begin
                ctr_d = ctr_q[w_ex_idx] - 2'b01;
            end
        end
    end

    // Table training: update on hit, allocate on taken miss, reset wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ex_valid_i) begin
            if (w_ex_hit) begin
                ctr_q[w_ex_idx] <= ctr_d;
                if (ex_taken_i) begin
                    target_q[w_ex_idx] <= ex_target_i;
                end
            end else if (ex_taken_i) begin
                valid_q[w_ex_idx]  <= 1'b1;
                tag_q[w_ex_idx]    <= w_ex_tag;
                target_q[w_ex_idx] <= ex_target_i;
                ctr_q[w_ex_idx]    <= 2'b10;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            if (ex_valid_i && (br_count_q != '1)) begin
                br_count_q <= br_count_q + CNT_W'(1);
            end
            if (mispredict_o && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + CNT_W'(1);
            end
        end
    end

    assign br_count_o   = br_count_q;
    assign miss_count_o = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 6;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int TSHIFT  = 6;   // PC bits below the tag: 2 offset + 4 index

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_br;
    int          m_miss;

    branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .if_pc_i          (if_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .ex_valid_i       (ex_valid),
        .ex_pc_i          (ex_pc),
        .ex_taken_i       (ex_taken),
        .ex_target_i      (ex_target),
        .ex_pred_taken_i  (ex_pred_taken),
        .ex_pred_target_i (ex_pred_target),
        .mispredict_o     (mispredict),
        .redirect_pc_o    (redirect_pc),
        .br_count_o       (br_count),
        .miss_count_o     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> TSHIFT));
    endfunction

    function automatic logic m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
        return m_ptaken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic logic m_mis();
        return ex_valid && ((ex_taken != ex_pred_taken) ||
                            (ex_taken && (ex_pred_target != ex_target)));
    endfunction

    task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt, input logic [31:0] ifpc);
        rst            = r;
        ex_valid       = v;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        if_pc          = ifpc;
        #1;
    endtask

    task automatic probe(input logic [31:0] ifpc);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, ifpc);
    endtask

    // Compare every output against the model's current (pre-edge) view
    task automatic check_model();
        chk("pred_taken", 32'(pred_taken), 32'(m_ptaken(if_pc)));
        chk("pred_target", pred_target, m_ptarget(if_pc));
        chk("mispredict", 32'(mispredict), 32'(m_mis()));
        if (ex_valid) begin
            chk("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
        end
        chk("br_count", 32'(br_count), 32'(m_br));
        chk("miss_count", 32'(miss_count), 32'(m_miss));
    endtask

    // Advance one clock and apply the same edge to the model
    task automatic tick();
        int  i;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_br   = 0;
            m_miss = 0;
        end else if (ex_valid) begin
            if (m_miss < CMAX && m_mis()) m_miss++;
            if (m_br < CMAX) m_br++;
            i = m_idx(ex_pc);
            if (m_hit(ex_pc)) begin
                if (ex_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (ex_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = ex_pc >> TSHIFT;
                m_tgt[i]   = ex_target;
                m_ctr[i]   = 2;
            end
        end
        @(negedge clk);
    endtask

    // Resolve a branch at pc using the model's prediction as the piped value
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        drive(1'b0, 1'b1, pc, tk, tgt, m_ptaken(pc), m_ptarget(pc), pc);
        check_model();
        tick();
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] pc, ifpc, tgt, ptgt;
        logic        r, v, tk, ptk;

        @(negedge clk);
        do_reset();

        // Reset state
        probe(32'h100);
        chk("rst_pred_taken", 32'(pred_taken), 32'h0);
        chk("rst_pred_target", pred_target, 32'h104);
        chk("rst_br", 32'(br_count), 32'h0);
        chk("rst_miss", 32'(miss_count), 32'h0);

        // First taken branch: mispredict and allocate
        drive(1'b0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
        chk("alloc_mis", 32'(mispredict), 32'h1);
        chk("alloc_redir", redirect_pc, 32'h80);
        check_model();
        tick();
        probe(32'h100);
        chk("alloc_pred", 32'(pred_taken), 32'h1);
        chk("alloc_tgt", pred_target, 32'h80);
        chk("alloc_br", 32'(br_count), 32'h1);
        chk("alloc_miss", 32'(miss_count), 32'h1);

        // Two not-taken resolutions walk ctr 10 -> 01 -> 00
        drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 32'h100);
        chk("nt1_mis", 32'(mispredict), 32'h1);
        chk("nt1_redir", redirect_pc, 32'h104);
        check_model();
        tick();
        probe(32'h100);
        chk("nt1_pred", 32'(pred_taken), 32'h0);
        drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 32'h100);
        chk("nt2_mis", 32'(mispredict), 32'h0);
        tick();
        probe(32'h100);
        chk("nt2_pred", 32'(pred_taken), 32'h0);

        // Five taken saturate at 11; one not-taken must still predict taken
        for (int k = 0; k < 5; k++) resolve(32'h100, 1'b1, 32'h80);
        probe(32'h100);
        chk("sat_pred", 32'(pred_taken), 32'h1);
        resolve(32'h100, 1'b0, 32'h80);
        probe(32'h100);
        chk("sat_dec_pred", 32'(pred_taken), 32'h1);

        // Aliasing at index 0
        do_reset();
        resolve(32'h100, 1'b1, 32'h80);
        resolve(32'h140, 1'b1, 32'h90);
        probe(32'h100);
        chk("alias_old", 32'(pred_taken), 32'h0);
        chk("alias_old_tgt", pred_target, 32'h104);
        probe(32'h140);
        chk("alias_new", 32'(pred_taken), 32'h1);
        chk("alias_new_tgt", pred_target, 32'h90);

        // Right direction, wrong target
        drive(1'b0, 1'b1, 32'h140, 1'b1, 32'hA0, 1'b1, 32'h80, 32'h140);
        chk("tgt_mis", 32'(mispredict), 32'h1);
        chk("tgt_redir", redirect_pc, 32'hA0);
        check_model();
        tick();
        probe(32'h140);
        chk("tgt_update", pred_target, 32'hA0);

        // Reset overrides a simultaneous resolution
        drive(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 32'h200);
        tick();
        probe(32'h200);
        chk("rstov_pred", 32'(pred_taken), 32'h0);
        chk("rstov_br", 32'(br_count), 32'h0);

        // Drive both counters into saturation
        for (int k = 0; k < CMAX + 6; k++) begin
            drive(1'b0, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304, 32'h300);
            check_model();
            tick();
        end
        probe(32'h300);
        chk("sat_miss", 32'(miss_count), 32'(CMAX));
        chk("sat_br", 32'(br_count), 32'(CMAX));

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) != 0);
            pc = 32'h1000 + 32'($urandom_range(0, 47)) * 4 + 32'($urandom_range(0, 3));
            ifpc = ($urandom_range(0, 3) == 0) ? pc
                 : 32'h1000 + 32'($urandom_range(0, 47)) * 4 + 32'($urandom_range(0, 3));
            tk  = 1'($urandom_range(0, 1));
            tgt = 32'h2000 + 32'($urandom_range(0, 3)) * 16;
            if ($urandom_range(0, 1) == 1) begin
                ptk  = m_ptaken(pc);
                ptgt = m_ptarget(pc);
            end else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = 32'h2000 + 32'($urandom_range(0, 3)) * 16;
            end
            drive(r, v, pc, tk, tgt, ptk, ptgt, ifpc);
            check_model();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
